b4_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4-to-1 tristate bus/decoded mux among 4 requesters.

---
 rtl/b4_bus_arbiter_pkg.sv | 13 +
 rtl/b4_bus_arbiter_rr_pick4.sv | 17 +
 rtl/b4_bus_arbiter.sv | 97 +++++++++
 tb/tb_b4_bus_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/b4_bus_arbiter_pkg.sv
// b4_bus_arbiter_pkg: shared state encoding, sizes and grant helper for the 4-source bus arbiter
package b4_bus_arbiter_pkg;
  localparam int N_SRC = 4;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_TURN  = 2'b10
  } state_t;
  function automatic logic [N_SRC-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return N_SRC'(1) << idx;
  endfunction
endpackage

// File: rtl/b4_bus_arbiter_rr_pick4.sv
// rr_pick4: round-robin winner search starting just after the last owner
module rr_pick4
  import b4_bus_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_any,
  output logic [IDX_W-1:0] o_win
);
  assign o_any = |i_req;
  // Scan farthest-first so the nearest requester after i_last overwrites last.
  always_comb begin
    o_win = i_last;
    for (int k = N_SRC; k >= 1; k--)
      if (i_req[i_last + IDX_W'(k)]) o_win = i_last + IDX_W'(k);
  end
endmodule

// File: rtl/b4_bus_arbiter.sv
// b4_bus_arbiter: round-robin owner of a shared 4-source bus with turnaround and hold limit
module b4_bus_arbiter
  import b4_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_req,
  output logic [N_SRC-1:0] o_gnt,
  output logic [N_SRC-1:0] o_en,
  output logic [IDX_W-1:0] o_sel,
  output logic             o_busy,
  output logic             o_revoke
);
  state_t             r_state, w_nstate;
  logic [IDX_W-1:0]   r_last, w_nlast;
  logic [IDX_W-1:0]   r_sel, w_nsel;
  logic [CNT_W-1:0]   r_cnt, w_ncnt;
  logic [N_SRC-1:0]   r_gnt, w_ngnt;
  logic               r_busy, r_revoke, w_nrevoke;
  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  rr_pick4 u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_win  (w_win)
  );
  always_comb begin
    w_nstate  = r_state;
    w_nlast   = r_last;
    w_nsel    = r_sel;
    w_ncnt    = r_cnt;
    w_ngnt    = r_gnt;
    w_nrevoke = 1'b0;
    case (r_state)
      S_IDLE, S_TURN: begin
        w_nstate = w_any ? S_GRANT : S_IDLE;
        w_ngnt   = w_any ? one_hot(w_win) : '0;
        w_nsel   = w_any ? w_win : r_sel;
        w_ncnt   = '0;
      end
      S_GRANT: begin
        // r_sel is the current owner while granted; a release takes priority over expiry.
        if (!i_req[r_sel]) begin
          w_nstate = S_TURN;
          w_nlast  = r_sel;
          w_ngnt   = '0;
          w_ncnt   = '0;
        end else if (|(i_req & ~r_gnt)) begin
          if (r_cnt == CNT_W'(MAX_HOLD - 1)) begin
            w_nstate  = S_TURN;
            w_nlast   = r_sel;
            w_ngnt    = '0;
            w_ncnt    = '0;
            w_nrevoke = 1'b1;
          end else begin
            w_ncnt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_ncnt = '0;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ngnt   = '0;
        w_ncnt   = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= IDX_W'(N_SRC - 1);
      r_sel    <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_revoke <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_last   <= w_nlast;
      r_sel    <= w_nsel;
      r_cnt    <= w_ncnt;
      r_gnt    <= w_ngnt;
      r_busy   <= (w_nstate != S_IDLE);
      r_revoke <= w_nrevoke;
    end
  end
  assign o_gnt    = r_gnt;
  assign o_en     = r_gnt;
  assign o_sel    = r_sel;
  assign o_busy   = r_busy;
  assign o_revoke = r_revoke;
endmodule

// File: tb/tb_b4_bus_arbiter.sv
// tb_b4_bus_arbiter: directed and random checks of the bus arbiter against an ownership-level model
module tb_b4_bus_arbiter;
  localparam int MAX_HOLD = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt, en;
  logic [1:0] sel;
  logic       busy, revoke;
  int         errors = 0;
  int         checks = 0;
  int         m_owner, m_last, m_held, m_sel;
  bit         m_turn, m_rev;
  logic [1:0] order[$];
  int         revs, bad;
  logic [3:0] prev, r;
  always #5 clk = ~clk;
  b4_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .o_gnt    (gnt),
    .o_en     (en),
    .o_sel    (sel),
    .o_busy   (busy),
    .o_revoke (revoke)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;
    m_turn  = 0;
    m_rev   = 0;
  endtask
  // Ownership model: who holds the bus, how long it has been contended, and whether a gap cycle is due.
  task automatic m_step(input logic [3:0] rq);
    int i;
    m_rev = 0;
    if (m_owner < 0) begin
      m_turn = 0;
      for (int d = 1; d <= 4; d++) begin
        i = (m_last + d) % 4;
        if (rq[i]) begin
          m_owner = i;
          m_sel   = i;
          m_held  = 0;
          break;
        end
      end
    end else if (!rq[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_turn  = 1;
    end else if ((rq & ~(4'b1 << m_owner)) != 4'b0) begin
      m_held++;
      if (m_held == MAX_HOLD) begin
        m_last  = m_owner;
        m_owner = -1;
        m_turn  = 1;
        m_rev   = 1;
      end
    end else begin
      m_held = 0;
    end
  endtask
  task automatic m_check();
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("gnt", gnt, eg);
    chk("en", en, eg);
    chk("sel", sel, m_sel);
    chk("busy", busy, (m_owner >= 0) || m_turn);
    chk("revoke", revoke, m_rev);
    chk("onehot", $countones(gnt) <= 1, 1);
  endtask
  task automatic cyc(input logic [3:0] rq);
    req = rq;
    @(posedge clk);
    m_step(rq);
    #1;
    m_check();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    m_check();
    @(posedge clk);
    #1;
    m_check();
    rst_n = 1'b1;
  endtask
  initial begin
    #2;
    req = 4'b0101;
    do_reset();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    cyc(4'b0101);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_en", en, 4'b0001);
    chk("t1_sel", sel, 2'd0);
    do_reset();
    revs = 0;
    prev = '0;
    order.delete();
    for (int c = 0; c < 37; c++) begin
      cyc(4'hF);
      if (revoke) revs++;
      if (gnt != 4'b0 && prev == 4'b0) order.push_back(sel);
      prev = gnt;
    end
    chk("t2_revokes", revs, 4);
    chk("t2_grants", order.size(), 5);
    for (int k = 0; k < order.size() && k < 5; k++) chk("t2_order", order[k], k % 4);
    do_reset();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(4'b0100);
      if (gnt !== 4'b0100 || revoke !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t3_single", bad, 0);
    do_reset();
    cyc(4'b0010);
    chk("t4_own", gnt, 4'b0010);
    cyc(4'b1001);
    chk("t4_turn_gnt", gnt, 4'b0000);
    chk("t4_turn_rev", revoke, 1'b0);
    chk("t4_turn_busy", busy, 1'b1);
    cyc(4'b1001);
    chk("t4_next_gnt", gnt, 4'b1000);
    chk("t4_next_sel", sel, 2'd3);
    do_reset();
    cyc(4'b0001);
    repeat (7) cyc(4'b0011);
    chk("t5_hold", gnt, 4'b0001);
    cyc(4'b0010);
    chk("t5_gnt", gnt, 4'b0000);
    chk("t5_rev", revoke, 1'b0);
    chk("t5_busy", busy, 1'b1);
    cyc(4'b0010);
    chk("t5_next", gnt, 4'b0010);
    do_reset();
    cyc(4'b0100);
    chk("t6_own", gnt, 4'b0100);
    req = 4'hF;
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_async_gnt", gnt, 4'b0000);
    chk("t6_async_en", en, 4'b0000);
    chk("t6_async_busy", busy, 1'b0);
    #2;
    rst_n = 1'b1;
    cyc(4'hF);
    chk("t6_restart", gnt, 4'b0001);
    do_reset();
    r = 4'($urandom);
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      cyc(r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
